// File: rtl/chip_ctrl_pkg.sv
// chip_ctrl_pkg: shared pump FSM states and pad pattern constants for the ChIP ctrl sequencer
package chip_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PARK} pump_state_e;
    localparam logic [2:0] PUMP_PAT [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    localparam logic [2:0] PUMP_PARK = 3'b111;
    localparam logic VALVE_CLOSED = 1'b1;
endpackage

// File: rtl/chip_ctrl_sequencer_phase_gen.sv
// peristaltic_phase_gen: 3-valve pump FSM with dwell, phase and stroke counters
module peristaltic_phase_gen
    import chip_ctrl_pkg::*;
#(
    parameter int DWELL_W  = 16,
    parameter int STROKE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                reverse_i,
    input  logic [DWELL_W-1:0]  dwell_i,
    input  logic [STROKE_W-1:0] strokes_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2:0]          pump_ctrl_o
);
    localparam logic [DWELL_W-1:0]  D_ONE = DWELL_W'(1);
    localparam logic [STROKE_W-1:0] S_ONE = STROKE_W'(1);

    pump_state_e         state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d, reload_q, reload_d;
    logic [STROKE_W-1:0] strokes_q, strokes_d;
    logic                rev_q, rev_d, last_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 3'd0;
            dwell_q   <= D_ONE;
            reload_q  <= D_ONE;
            strokes_q <= '0;
            rev_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dwell_q   <= dwell_d;
            reload_q  <= reload_d;
            strokes_q <= strokes_d;
            rev_q     <= rev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dwell_d    = dwell_q;
        reload_d   = reload_q;
        strokes_d  = strokes_q;
        rev_d      = rev_q;
        last_phase = rev_q ? (phase_q == 3'd0) : (phase_q == 3'd5);
        case (state_q)
            IDLE: if (start_i && !abort_i) begin
                // a zero dwell would never expire, so it runs as one cycle per phase
                rev_d     = reverse_i;
                reload_d  = (dwell_i == '0) ? D_ONE : dwell_i;
                dwell_d   = (dwell_i == '0) ? D_ONE : dwell_i;
                strokes_d = strokes_i;
                phase_d   = reverse_i ? 3'd5 : 3'd0;
                state_d   = (strokes_i == '0) ? PARK : RUN;
            end
            RUN: if (abort_i) begin
                state_d = PARK;
            end else if (dwell_q == D_ONE) begin
                dwell_d = reload_q;
                phase_d = last_phase ? (rev_q ? 3'd5 : 3'd0) : (rev_q ? phase_q - 3'd1 : phase_q + 3'd1);
                if (last_phase) begin
                    strokes_d = strokes_q - S_ONE;
                    state_d   = (strokes_q == S_ONE) ? PARK : RUN;
                end
            end else begin
                dwell_d = dwell_q - D_ONE;
            end
            PARK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == PARK;
    assign pump_ctrl_o = (state_q == RUN) ? PUMP_PAT[phase_q] : PUMP_PARK;
endmodule

// File: rtl/chip_ctrl_sequencer.sv
// chip_ctrl_sequencer: valve command register bank plus peristaltic pump sequencer for ChIP ctrl pads
module chip_ctrl_sequencer
    import chip_ctrl_pkg::*;
#(
    parameter int NUM_VALVES = 20,
    parameter int DWELL_W    = 16,
    parameter int STROKE_W   = 8,
    localparam int IDX_W     = $clog2(NUM_VALVES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [IDX_W-1:0]      cmd_idx_i,
    input  logic                  cmd_close_i,
    output logic                  cmd_err_o,
    input  logic                  pump_start_i,
    input  logic                  pump_reverse_i,
    input  logic [DWELL_W-1:0]    pump_dwell_i,
    input  logic [STROKE_W-1:0]   pump_strokes_i,
    input  logic                  pump_abort_i,
    output logic                  pump_busy_o,
    output logic                  pump_done_o,
    output logic [NUM_VALVES-1:0] valve_ctrl_o,
    output logic [2:0]            pump_ctrl_o
);
    localparam logic [IDX_W:0] NV = (IDX_W+1)'(NUM_VALVES);

    logic [NUM_VALVES-1:0] valve_q, valve_d;
    logic                  ready_q, err_q, err_d, in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            valve_q <= {NUM_VALVES{VALVE_CLOSED}};
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valve_q <= valve_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
        end
    end

    always_comb begin
        valve_d  = valve_q;
        in_range = {1'b0, cmd_idx_i} < NV;
        err_d    = cmd_valid_i && ready_q && !in_range;
        if (cmd_valid_i && ready_q && in_range) valve_d[cmd_idx_i] = cmd_close_i;
    end

    assign cmd_ready_o  = ready_q;
    assign cmd_err_o    = err_q;
    assign valve_ctrl_o = valve_q;

    peristaltic_phase_gen #(.DWELL_W(DWELL_W), .STROKE_W(STROKE_W)) u_pump (
        .clk         (clk),
        .rst         (rst),
        .start_i     (pump_start_i),
        .reverse_i   (pump_reverse_i),
        .dwell_i     (pump_dwell_i),
        .strokes_i   (pump_strokes_i),
        .abort_i     (pump_abort_i),
        .busy_o      (pump_busy_o),
        .done_o      (pump_done_o),
        .pump_ctrl_o (pump_ctrl_o)
    );
endmodule

// File: tb/tb_chip_ctrl_sequencer.sv
// tb_chip_ctrl_sequencer: vector table, directed pump sequences and randomized run against a queue model
module tb_chip_ctrl_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_close = 1'b0, cmd_ready, cmd_err;
    logic [4:0]  cmd_idx = '0;
    logic        pump_start = 1'b0, pump_reverse = 1'b0, pump_abort = 1'b0, pump_busy, pump_done;
    logic [15:0] pump_dwell = '0;
    logic [7:0]  pump_strokes = '0;
    logic [19:0] valve_ctrl;
    logic [2:0]  pump_ctrl;

    int total = 0, bad = 0;

    chip_ctrl_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_idx_i(cmd_idx),
        .cmd_close_i(cmd_close), .cmd_err_o(cmd_err),
        .pump_start_i(pump_start), .pump_reverse_i(pump_reverse), .pump_dwell_i(pump_dwell),
        .pump_strokes_i(pump_strokes), .pump_abort_i(pump_abort),
        .pump_busy_o(pump_busy), .pump_done_o(pump_done),
        .valve_ctrl_o(valve_ctrl), .pump_ctrl_o(pump_ctrl)
    );

    always #5 clk = ~clk;

    // expected {pump_ctrl, busy, done} per upcoming cycle
    localparam logic [4:0] IDLE_OBS = 5'b11100;
    localparam logic [4:0] PARK_OBS = 5'b11111;
    logic [2:0]  pat [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [4:0]  q [$];
    logic [4:0]  cur = IDLE_OBS;
    logic [19:0] m_valve = '1;
    logic        m_ready = 1'b0, m_err = 1'b0;

    task automatic model_update();
        int d;
        if (rst) begin
            m_valve = '1; m_ready = 1'b0; m_err = 1'b0;
            q.delete(); cur = IDLE_OBS;
            return;
        end
        m_err = cmd_valid && m_ready && (cmd_idx >= 5'd20);
        if (cmd_valid && m_ready && cmd_idx < 5'd20) m_valve[cmd_idx] = cmd_close;
        m_ready = 1'b1;
        if (cur[1] && !cur[0] && pump_abort) begin
            q.delete();
            q.push_back(PARK_OBS);
        end else if (!cur[1] && pump_start && !pump_abort) begin
            d = (pump_dwell == 0) ? 1 : int'(pump_dwell);
            for (int s = 0; s < int'(pump_strokes); s++)
                for (int p = 0; p < 6; p++)
                    for (int k = 0; k < d; k++)
                        q.push_back({pat[pump_reverse ? 5 - p : p], 2'b10});
            q.push_back(PARK_OBS);
        end
        cur = (q.size() > 0) ? q.pop_front() : IDLE_OBS;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("model_valve", {11'd0, valve_ctrl, cmd_ready, cmd_err}, {11'd0, m_valve, m_ready, m_err});
        check("model_pump", {27'd0, pump_ctrl, pump_busy, pump_done}, {27'd0, cur});
    endtask

    task automatic start(input logic rev, input logic [15:0] dw, input logic [7:0] st);
        pump_start = 1'b1; pump_reverse = rev; pump_dwell = dw; pump_strokes = st;
        tick();
        pump_start = 1'b0;
    endtask

    typedef struct {
        logic        valid;
        logic [4:0]  idx;
        logic        close;
        logic        exp_err;
        logic [19:0] exp_valve;
    } vec_t;
    vec_t vecs [9];

    logic [2:0] fwd2 [12];
    int n;

    initial begin
        vecs[0] = '{1'b1, 5'd3,  1'b0, 1'b0, 20'hFFFF7};
        vecs[1] = '{1'b1, 5'd25, 1'b0, 1'b1, 20'hFFFF7};
        vecs[2] = '{1'b1, 5'd19, 1'b0, 1'b0, 20'h7FFF7};
        vecs[3] = '{1'b1, 5'd0,  1'b0, 1'b0, 20'h7FFF6};
        vecs[4] = '{1'b1, 5'd3,  1'b1, 1'b0, 20'h7FFFE};
        vecs[5] = '{1'b1, 5'd20, 1'b1, 1'b1, 20'h7FFFE};
        vecs[6] = '{1'b1, 5'd31, 1'b0, 1'b1, 20'h7FFFE};
        vecs[7] = '{1'b0, 5'd5,  1'b0, 1'b0, 20'h7FFFE};
        vecs[8] = '{1'b1, 5'd5,  1'b0, 1'b0, 20'h7FFDE};
        fwd2 = '{3'b101, 3'b101, 3'b100, 3'b100, 3'b110, 3'b110,
                 3'b010, 3'b010, 3'b011, 3'b011, 3'b001, 3'b001};

        // reset release
        tick(); tick();
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_valve", {12'd0, valve_ctrl}, 32'hFFFFF);
        check("rst_pump", {29'd0, pump_ctrl}, 32'd7);
        rst = 1'b0;
        tick();
        check("ready_rise", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            cmd_valid = vecs[i].valid; cmd_idx = vecs[i].idx; cmd_close = vecs[i].close;
            tick();
            check($sformatf("vec%0d_err", i), {31'd0, cmd_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_valve", i), {12'd0, valve_ctrl}, {12'd0, vecs[i].exp_valve});
        end
        cmd_valid = 1'b0;
        tick();
        check("err_one_cycle", {31'd0, cmd_err}, 32'd0);

        // forward dwell 2, one stroke
        start(1'b0, 16'd2, 8'd1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("fwd_ph%0d", i), {29'd0, pump_ctrl}, {29'd0, fwd2[i]});
            check("fwd_busy", {31'd0, pump_busy}, 32'd1);
            tick();
        end
        check("fwd_park", {29'd0, pump_ctrl, pump_busy, pump_done}, 32'h1F);
        tick();
        check("fwd_idle", {29'd0, pump_ctrl, pump_busy, pump_done}, 32'h1C);

        // reverse dwell 0, two strokes
        start(1'b1, 16'd0, 8'd2);
        check("rev_first", {29'd0, pump_ctrl}, 32'd1);
        n = 0;
        while (!pump_done && n < 100) begin n++; tick(); end
        check("rev_len", n, 32'd12);
        tick();

        // abort on the 4th RUN cycle, then a start during PARK
        start(1'b0, 16'd3, 8'd2);
        tick(); tick(); tick();
        check("abort_pre", {29'd0, pump_ctrl}, 32'b100);
        pump_abort = 1'b1;
        tick();
        pump_abort = 1'b0;
        check("abort_park", {29'd0, pump_ctrl, pump_busy, pump_done}, 32'h1F);
        pump_start = 1'b1; pump_strokes = 8'd1;
        tick();
        pump_start = 1'b0;
        check("abort_idle", {30'd0, pump_busy, pump_done}, 32'd0);
        tick();
        check("no_queue", {30'd0, pump_busy, pump_done}, 32'd0);

        // zero strokes
        start(1'b0, 16'd4, 8'd0);
        check("zero_park", {29'd0, pump_ctrl, pump_busy, pump_done}, 32'h1F);
        tick();
        check("zero_idle", {31'd0, pump_busy}, 32'd0);

        // reset mid-run
        cmd_valid = 1'b1; cmd_idx = 5'd7; cmd_close = 1'b0;
        tick();
        cmd_valid = 1'b0;
        start(1'b1, 16'd5, 8'd3);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_valve", {12'd0, valve_ctrl}, 32'hFFFFF);
        check("midrst_pump", {27'd0, pump_ctrl, pump_busy, pump_done}, 32'h1C);
        check("midrst_hs", {30'd0, cmd_ready, cmd_err}, 32'd0);
        rst = 1'b0;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            cmd_valid    = $urandom_range(0, 1) == 1;
            cmd_idx      = 5'($urandom_range(0, 31));
            cmd_close    = $urandom_range(0, 1) == 1;
            pump_start   = ($urandom_range(0, 7) == 0);
            pump_abort   = ($urandom_range(0, 39) == 0);
            pump_reverse = $urandom_range(0, 1) == 1;
            pump_dwell   = 16'($urandom_range(0, 3));
            pump_strokes = 8'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
